seg_display_arbiter: RTL and testbench
======================================

// Module: seg_display_arbiter
// PURPOSE
//  Arbitrates two requesters (e.g. ping-pong counter, status/message source) for the shared
//  4-digit active-low seven-segment display. Grants one owner at a time, round-robin on contention,
//  with a minimum ownership time. Scans the owner's 16-bit hex word onto an/out, one digit per clk18.
//  Sits between the datapath blocks and the board display pins.
// PARAMETERS
//  HOLD_TICKS  64  min clk18 cycles an owner keeps the grant while the other requests; legal >= 1
// PORTS
//  clk18   in   1   clock; all state updates on posedge clk18
//  rst_n   in   1   reset, synchronous, active-low
//  req0    in   1   requester 0 wants the display (level, held while wanted)
//  data0   in   16  requester 0 hex word; [15:12] -> an[3] (leftmost) ... [3:0] -> an[0]
//  req1    in   1   requester 1 wants the display
//  data1   in   16  requester 1 hex word, same mapping
//  gnt0    out  1   registered grant to requester 0
//  gnt1    out  1   registered grant to requester 1
//  an      out  4   digit enables, active-low, one-hot-zero
//  out     out  8   segments {a,b,c,d,e,f,g,dp}, active-low; dp always 1 (off)
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state=IDLE, gnt0=gnt1=0, hold_cnt=0, scan_cnt=0, last=1
//    (req0 wins first tie), an=4'b1111, out=8'hFF. Reset mid-grant aborts immediately, same values.
//  - FSM IDLE/OWN0/OWN1; gnt0=(state==OWN0), gnt1=(state==OWN1); never both high.
//  - IDLE: only reqX -> OWNX next cycle; both -> OWN of side != last; none -> stay. last<=X on entry.
//  - OWNX: hold_cnt<=0 on entry, +1 per cycle, saturates at HOLD_TICKS-1.
//    reqX=0 -> IDLE next cycle (regardless of hold_cnt); one idle cycle precedes any new grant.
//    reqX=1, reqY=1, hold_cnt==HOLD_TICKS-1 -> OWNY next cycle (direct handoff, hold_cnt<=0, last<=Y).
//    reqX=1, reqY=0 -> stay indefinitely. reqX=0 has priority over handoff.
//  - Contended steady state: each grant lasts exactly HOLD_TICKS cycles, strictly alternating.
//  - hold_cnt width $clog2(HOLD_TICKS)+1; HOLD_TICKS=1 alternates every cycle under contention.
//  - Scan: 2-bit scan_cnt increments every cycle, wraps 3->0. Registered outputs, 1-cycle latency:
//    an <= ~(4'b0001<<scan_cnt); out <= seg(nibble scan_cnt of current owner's data, this cycle).
//  - In IDLE, out <= 8'b11111101 (dash) on every digit; an keeps scanning.
//  - Owner data is not latched: changes on dataX appear on the next scanned digit.
//  - seg(): 0 03,1 9F,2 25,3 0D,4 99,5 49,6 41,7 1F,8 01,9 09,A 11,b C1,C 63,d 85,E 61,F 71 (hex).
// CONFIGURATION
//  BLANK_LEADING_ZERO_EN defined: for the owner word, leading zero nibbles among digits 3..1
//   (scanning from digit 3 down to first nonzero) drive out=8'hFF; digit 0 always shown; IDLE dashes
//   unaffected. Undefined: all four digits always decoded (zeros show 03).
// TESTING
//  1 rst_n=0 2 cycles -> gnt=00, an=1111, out=FF; release, no req -> an 1110,1101,1011,0111 rotating, out=FD.
//  2 req0=1, data0=16'h12AF -> gnt0=1 one cycle later; an 1110/1101/1011/0111 -> out 71/11/25/9F.
//  3 HOLD_TICKS=4, req0=req1=1 from IDLE -> gnt0 4 cycles, gnt1 4 cycles, repeat; gnt0&gnt1 never 1.
//  4 OWN1 with hold_cnt=1, drop req1, req0=1 -> gnt1=0 next cycle, one IDLE cycle (out=FD), then gnt0=1.
//  5 owner data 16'h0005: macro on -> digits 3..1 out=FF, digit0 49; macro off -> 03,03,03,49.
//  6 rst_n=0 during OWN1 -> next edge all reset values; then req0=req1=1 -> gnt0 granted first.

Source files
------------

// File: rtl/seg_display_arbiter_if.sv
// Display bus shared by two requesters and the seven-segment arbiter.
// master = requester side, slave = arbiter side.
interface seg_display_arbiter_if;
  logic        req0;
  logic [15:0] data0;
  logic        req1;
  logic [15:0] data1;
  logic        gnt0;
  logic        gnt1;
  logic [3:0]  an;
  logic [7:0]  out;

  modport master (
    output req0, data0, req1, data1,
    input  gnt0, gnt1, an, out
  );

  modport slave (
    input  req0, data0, req1, data1,
    output gnt0, gnt1, an, out
  );
endinterface

// File: rtl/seg_display_arbiter.sv
// Round-robin owner arbitration + 4-digit scan of the owner's hex word.
// Optional BLANK_LEADING_ZERO_EN blanks leading zero digits 3..1.
module seg_display_arbiter #(
  parameter int HOLD_TICKS = 64
) (
  input  logic                  clk18,
  input  logic                  rst_n,
  seg_display_arbiter_if.slave  disp
);

  localparam int HW = $clog2(HOLD_TICKS) + 1;
  localparam logic [HW-1:0] HMAX = HW'(HOLD_TICKS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_OWN0 = 2'd1;
  localparam logic [1:0] S_OWN1 = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          last_q, last_d;
  logic [1:0]    scan_q;
  logic [3:0]    an_q;
  logic [7:0]    out_q, out_d;
  logic [15:0]   word;
  logic [3:0]    nib;
  logic          blank;
  logic          owned;
  logic [HW-1:0] hold_inc;

  function automatic logic [7:0] seg7(input logic [3:0] n);
    logic [7:0] s;
    unique case (n)
      4'h0: s = 8'h03;
      4'h1: s = 8'h9F;
      4'h2: s = 8'h25;
      4'h3: s = 8'h0D;
      4'h4: s = 8'h99;
      4'h5: s = 8'h49;
      4'h6: s = 8'h41;
      4'h7: s = 8'h1F;
      4'h8: s = 8'h01;
      4'h9: s = 8'h09;
      4'hA: s = 8'h11;
      4'hB: s = 8'hC1;
      4'hC: s = 8'h63;
      4'hD: s = 8'h85;
      4'hE: s = 8'h61;
      default: s = 8'h71;
    endcase
    return s;
  endfunction

  assign hold_inc = (hold_q == HMAX) ? hold_q : hold_q + 1'b1;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_inc;
    last_d  = last_q;
    unique case (state_q)
      S_IDLE: begin
        hold_d = '0;
        if (disp.req0 && disp.req1) begin
          state_d = last_q ? S_OWN0 : S_OWN1;
          last_d  = ~last_q;
        end else if (disp.req0) begin
          state_d = S_OWN0;
          last_d  = 1'b0;
        end else if (disp.req1) begin
          state_d = S_OWN1;
          last_d  = 1'b1;
        end
      end
      S_OWN0: begin
        if (!disp.req0) begin
          state_d = S_IDLE;
          hold_d  = '0;
        end else if (disp.req1 && hold_q == HMAX) begin
          state_d = S_OWN1;
          hold_d  = '0;
          last_d  = 1'b1;
        end
      end
      S_OWN1: begin
        if (!disp.req1) begin
          state_d = S_IDLE;
          hold_d  = '0;
        end else if (disp.req0 && hold_q == HMAX) begin
          state_d = S_OWN0;
          hold_d  = '0;
          last_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        hold_d  = '0;
      end
    endcase
  end

  // Owner word is read live, so data changes show on the next digit.
  assign owned = (state_q == S_OWN0) || (state_q == S_OWN1);
  assign word  = (state_q == S_OWN1) ? disp.data1 : disp.data0;

  always_comb begin
    nib = word[3:0];
    unique case (scan_q)
      2'd0: nib = word[3:0];
      2'd1: nib = word[7:4];
      2'd2: nib = word[11:8];
      default: nib = word[15:12];
    endcase
  end

`ifdef BLANK_LEADING_ZERO_EN
  always_comb begin
    blank = 1'b0;
    unique case (scan_q)
      2'd3: blank = (word[15:12] == 4'h0);
      2'd2: blank = (word[15:8] == 8'h00);
      2'd1: blank = (word[15:4] == 12'h000);
      default: blank = 1'b0;
    endcase
  end
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    out_d = 8'hFD;
    if (owned) out_d = blank ? 8'hFF : seg7(nib);
  end

  always_ff @(posedge clk18) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
      last_q  <= 1'b1;
      scan_q  <= 2'd0;
      an_q    <= 4'hF;
      out_q   <= 8'hFF;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
      scan_q  <= scan_q + 2'd1;
      an_q    <= ~(4'b0001 << scan_q);
      out_q   <= out_d;
    end
  end

  assign disp.gnt0 = (state_q == S_OWN0);
  assign disp.gnt1 = (state_q == S_OWN1);
  assign disp.an   = an_q;
  assign disp.out  = out_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Bench for seg_display_arbiter: vector table, directed corners,
// random traffic against an ownership-count model.
module tb_seg_display_arbiter;

  localparam int H = 4;

  logic clk18 = 1'b0;
  logic rst_n;

  seg_display_arbiter_if disp();

  seg_display_arbiter #(.HOLD_TICKS(H)) dut (
    .clk18 (clk18),
    .rst_n (rst_n),
    .disp  (disp)
  );

  always #5 clk18 = ~clk18;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] seg_tab [16] = '{
    8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
    8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
  };

  // Model: owner -1 idle; held = cycles owned so far
  int         m_owner;
  int         m_held;
  int         m_last;
  int         m_scan;
  logic [3:0] m_an;
  logic [7:0] m_out;

  function automatic logic [7:0] m_digit(logic [15:0] w, int d);
    logic [15:0] up;
    logic [3:0]  n;
    up = w >> (4 * d);
    n  = up[3:0];
`ifdef BLANK_LEADING_ZERO_EN
    if (d > 0 && up == 16'h0) return 8'hFF;
`endif
    return seg_tab[n];
  endfunction

  task automatic model_step();
    bit          r [2];
    logic [15:0] d [2];
    r[0] = disp.req0;
    r[1] = disp.req1;
    d[0] = disp.data0;
    d[1] = disp.data1;
    if (!rst_n) begin
      m_owner = -1;
      m_held  = 0;
      m_last  = 1;
      m_scan  = 0;
      m_an    = 4'hF;
      m_out   = 8'hFF;
      return;
    end
    m_an  = ~(4'b0001 << m_scan);
    m_out = (m_owner < 0) ? 8'hFD : m_digit(d[m_owner], m_scan);
    m_scan = (m_scan + 1) % 4;
    if (m_owner < 0) begin
      if (r[0] && r[1]) m_owner = 1 - m_last;
      else if (r[0]) m_owner = 0;
      else if (r[1]) m_owner = 1;
      if (m_owner >= 0) begin
        m_last = m_owner;
        m_held = 1;
      end
    end else if (!r[m_owner]) begin
      m_owner = -1;
    end else if (r[1 - m_owner] && m_held >= H) begin
      m_owner = 1 - m_owner;
      m_last  = m_owner;
      m_held  = 1;
    end else begin
      m_held++;
    end
  endtask

  task automatic tick();
    @(posedge clk18);
    model_step();
    @(negedge clk18);
  endtask

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    disp.req0 = 1'b0;
    disp.req1 = 1'b0;
    tick();
    tick();
  endtask

  typedef struct {
    logic        rst;
    logic        r0;
    logic        r1;
    logic [15:0] d0;
    logic [1:0]  gnt;
    logic [3:0]  an;
    logic [7:0]  out;
  } vec_t;

  vec_t tv [13];

  logic [7:0] z;

  initial begin
    tv[0]  = '{1'b0, 1'b0, 1'b0, 16'h12AF, 2'b00, 4'hF, 8'hFF};
    tv[1]  = '{1'b0, 1'b0, 1'b0, 16'h12AF, 2'b00, 4'hF, 8'hFF};
    tv[2]  = '{1'b1, 1'b0, 1'b0, 16'h12AF, 2'b00, 4'hE, 8'hFD};
    tv[3]  = '{1'b1, 1'b0, 1'b0, 16'h12AF, 2'b00, 4'hD, 8'hFD};
    tv[4]  = '{1'b1, 1'b0, 1'b0, 16'h12AF, 2'b00, 4'hB, 8'hFD};
    tv[5]  = '{1'b1, 1'b0, 1'b0, 16'h12AF, 2'b00, 4'h7, 8'hFD};
    tv[6]  = '{1'b1, 1'b1, 1'b0, 16'h12AF, 2'b10, 4'hE, 8'hFD};
    tv[7]  = '{1'b1, 1'b1, 1'b0, 16'h12AF, 2'b10, 4'hD, 8'h11};
    tv[8]  = '{1'b1, 1'b1, 1'b0, 16'h12AF, 2'b10, 4'hB, 8'h25};
    tv[9]  = '{1'b1, 1'b1, 1'b0, 16'h12AF, 2'b10, 4'h7, 8'h9F};
    tv[10] = '{1'b1, 1'b1, 1'b0, 16'h12AF, 2'b10, 4'hE, 8'h71};
    tv[11] = '{1'b1, 1'b0, 1'b0, 16'h12AF, 2'b00, 4'hD, 8'h11};
    tv[12] = '{1'b1, 1'b0, 1'b0, 16'h12AF, 2'b00, 4'hB, 8'hFD};

    rst_n = 1'b0;
    disp.req0  = 1'b0;
    disp.req1  = 1'b0;
    disp.data0 = 16'h0;
    disp.data1 = 16'h0;
    @(negedge clk18);

    for (int i = 0; i < 13; i++) begin
      rst_n      = tv[i].rst;
      disp.req0  = tv[i].r0;
      disp.req1  = tv[i].r1;
      disp.data0 = tv[i].d0;
      tick();
      chk($sformatf("vec%0d_gnt", i),
          {14'h0, disp.gnt0, disp.gnt1}, {14'h0, tv[i].gnt});
      chk($sformatf("vec%0d_an", i), {12'h0, disp.an}, {12'h0, tv[i].an});
      chk($sformatf("vec%0d_out", i), {8'h0, disp.out}, {8'h0, tv[i].out});
    end

    // Contention alternates every H cycles, req0 first
    do_reset();
    rst_n = 1'b1;
    disp.req0 = 1'b1;
    disp.req1 = 1'b1;
    for (int k = 0; k < 6 * H; k++) begin
      tick();
      chk($sformatf("rr%0d_gnt0", k), {15'h0, disp.gnt0},
          {15'h0, ((k / H) % 2 == 0) ? 1'b1 : 1'b0});
      chk($sformatf("rr%0d_gnt1", k), {15'h0, disp.gnt1},
          {15'h0, ((k / H) % 2 == 1) ? 1'b1 : 1'b0});
    end

    // Early release from OWN1 forces one idle cycle
    do_reset();
    rst_n = 1'b1;
    disp.req1  = 1'b1;
    disp.data1 = 16'h3C7E;
    tick();
    tick();
    chk("rel_own1", {14'h0, disp.gnt0, disp.gnt1}, 16'h0001);
    disp.req1 = 1'b0;
    disp.req0 = 1'b1;
    tick();
    chk("rel_idle", {14'h0, disp.gnt0, disp.gnt1}, 16'h0000);
    tick();
    chk("rel_gnt0", {14'h0, disp.gnt0, disp.gnt1}, 16'h0002);
    chk("rel_dash", {8'h0, disp.out}, 16'h00FD);
    chk("rel_an", {12'h0, disp.an}, 16'h0007);

    // Leading zeros on word 0005
    do_reset();
    rst_n = 1'b1;
    disp.req0  = 1'b1;
    disp.req1  = 1'b0;
    disp.data0 = 16'h0005;
`ifdef BLANK_LEADING_ZERO_EN
    z = 8'hFF;
`else
    z = 8'h03;
`endif
    tick();
    tick();
    chk("lz_d1", {8'h0, disp.out}, {8'h0, z});
    tick();
    chk("lz_d2", {8'h0, disp.out}, {8'h0, z});
    tick();
    chk("lz_d3", {8'h0, disp.out}, {8'h0, z});
    tick();
    chk("lz_d0", {8'h0, disp.out}, 16'h0049);

    // Reset mid-grant, then req0 wins the first tie
    do_reset();
    rst_n = 1'b1;
    disp.req1 = 1'b1;
    tick();
    tick();
    tick();
    chk("mid_own1", {14'h0, disp.gnt0, disp.gnt1}, 16'h0001);
    rst_n = 1'b0;
    tick();
    chk("mid_gnt", {14'h0, disp.gnt0, disp.gnt1}, 16'h0000);
    chk("mid_an", {12'h0, disp.an}, 16'h000F);
    chk("mid_out", {8'h0, disp.out}, 16'h00FF);
    rst_n = 1'b1;
    disp.req0 = 1'b1;
    tick();
    chk("mid_tie", {14'h0, disp.gnt0, disp.gnt1}, 16'h0002);

    // Random traffic against the model
    for (int i = 0; i < 800; i++) begin
      rst_n = ($urandom_range(0, 149) != 0);
      if ($urandom_range(0, 6) == 0) disp.req0 = ~disp.req0;
      if ($urandom_range(0, 6) == 0) disp.req1 = ~disp.req1;
      disp.data0 = 16'($urandom);
      disp.data1 = 16'($urandom);
      if ($urandom_range(0, 2) == 0)
        disp.data0 = disp.data0 >> (4 * $urandom_range(1, 4));
      if ($urandom_range(0, 2) == 0)
        disp.data1 = disp.data1 >> (4 * $urandom_range(1, 4));
      tick();
      chk("rnd_gnt0", {15'h0, disp.gnt0},
          {15'h0, (m_owner == 0) ? 1'b1 : 1'b0});
      chk("rnd_gnt1", {15'h0, disp.gnt1},
          {15'h0, (m_owner == 1) ? 1'b1 : 1'b0});
      chk("rnd_an", {12'h0, disp.an}, {12'h0, m_an});
      chk("rnd_out", {8'h0, disp.out}, {8'h0, m_out});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
